mult_div: RTL and testbench
===========================

# mult_div

Multicycle signed multiply/divide unit for the multicycle MIPS datapath. It computes MULT (64-bit product) and DIV (quotient and remainder) from the two 32-bit register operands and holds the results in its own Hi and Lo registers. Those registers drive the Hi and Lo inputs of the register-bank write-data mux, which MFHI/MFLO select. The control unit starts an operation, waits for Done, and treats DivZero as the divide-by-zero exception cause.

## Interface
- No parameters. Width is fixed at 32 bits.
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- A  in  32  rs operand: multiplicand or dividend (signed)
- B  in  32  rt operand: multiplier or divisor (signed)
- MultStart  in  1  start MULT; sampled only in IDLE
- DivStart  in  1  start DIV; sampled only in IDLE
- Hi  out  32  MULT: product[63:32]; DIV: remainder
- Lo  out  32  MULT: product[31:0]; DIV: quotient
- Busy  out  1  high while an operation is in flight (any state other than IDLE)
- Done  out  1  one-cycle pulse; Hi/Lo hold the new result
- DivZero  out  1  one-cycle pulse; DIV with B == 0 was rejected

## Operation
- States: IDLE, MULT, DIV, FIN.
- IDLE transitions:
  - MultStart=1: latch A and B, load the Booth accumulator {32'b0, B, 1'b0}, set count = 32, go to MULT.
  - DivStart=1 and B != 0: latch |A| and |B| as 32-bit unsigned values (|0x80000000| = 0x80000000), latch sign(A) and sign(B), clear the remainder, set count = 32, go to DIV.
  - DivStart=1 and B == 0: stay in IDLE, pulse DivZero on the next edge, leave Hi/Lo unchanged, no Done.
  - MultStart and DivStart both high: MultStart wins and DivStart is ignored.
- MULT: one radix-2 Booth step per cycle.
  - Examine the low 2 bits: 01 adds A to the upper 32 bits; 10 subtracts A from the upper 32 bits; 00 and 11 do nothing.
  - Then arithmetic right shift by 1 over 65 bits.
  - Decrement count. When count reaches 0, go to FIN.
- DIV: one unsigned restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Form trial = rem − |B| at 33 bits. If trial is non-negative, rem = trial and set quo bit 0 to 1.
  - Decrement count. When count reaches 0, go to FIN.
- FIN writes Hi/Lo, sets Done, and returns to IDLE.
  - MULT result: Hi = acc[64:33], Lo = acc[32:1].
  - DIV quotient: Lo = −quo if sign(A) ≠ sign(B), else quo.
  - DIV remainder: Hi = −rem if sign(A) = 1, else rem. The remainder takes the sign of the dividend.
  - All negation is 32-bit two's complement with wrap: −2^31 / −1 gives Lo = 0x80000000, Hi = 0.
- A start pulse seen while Busy is ignored and not queued.
- Hi/Lo change only in FIN or on reset. They hold their value indefinitely otherwise.
- Operand inputs are don't-care after the start edge. Only the latched copies are used.

## Timing
- Reset (asynchronous assert, any state, including mid-operation):
  - state = IDLE; Hi = 0; Lo = 0; Busy = 0; Done = 0; DivZero = 0.
  - The in-flight operation is discarded.
- All outputs are registered. Busy is a decode of registered state.
- Latency, taking E0 as the edge that samples the start:
  - Busy goes high after E0.
  - E1..E32 are the 32 iteration cycles. The E32 edge moves to FIN, so FIN occupies the cycle after E32.
  - At E33, Hi/Lo update, Done = 1, and state returns to IDLE.
- Done is high for exactly the one cycle following E33, and Busy is low in that same cycle.
- A new start asserted in the Done cycle is accepted at E34 (back-to-back issue). Total period: 34 cycles per operation.
- DivZero is high for exactly the one cycle after the sampling edge. Busy stays low throughout.

## Test plan
- MULT A=0xFFFFFFFD (−3), B=5 -> at E33 Done pulses, Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; Busy high for exactly 33 cycles.
- MULT A=B=0x80000000 -> Hi=0x40000000, Lo=0x00000000; then MULT 0x7FFFFFFF×0x7FFFFFFF issued in the Done cycle -> Hi=0x3FFFFFFF, Lo=0x00000001 at E33 of the second operation.
- DIV A=0xFFFFFFF9 (−7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV A=7, B=0xFFFFFFFE -> Lo=0xFFFFFFFD, Hi=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0. DIV A=5, B=0 -> DivZero pulses 1 cycle, no Done, Hi/Lo keep their previous values, Busy never high.
- MultStart and DivStart together with A=6, B=3 -> MULT performed, Hi=0, Lo=18. A start asserted mid-operation is ignored and the result is unaffected.
- Reset driven low at iteration 15 of a DIV -> Hi=Lo=0, Busy=0 immediately without waiting for a clock edge; no Done after reset release; a fresh MULT 2×3 then yields Lo=6.

Source files
------------

// File: rtl/mult_div.sv
// mult_div: multicycle signed multiply/divide unit with private Hi/Lo result
// registers. MULT uses radix-2 Booth recoding, DIV uses unsigned restoring
// division on operand magnitudes followed by a sign fix-up. Each operation
// takes 32 iteration cycles plus one FIN cycle that writes Hi/Lo.
module mult_div (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MultStart,
    input  logic        DivStart,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;

    logic [64:0] acc_r;
    logic [31:0] mcand_r;
    logic [31:0] divisor_r;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [5:0]  count_r;
    logic        sign_a_r;
    logic        sign_b_r;
    logic        is_div_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        done_r;
    logic        divzero_r;

    logic [32:0] booth_upper_s;
    logic [32:0] booth_sum_s;
    logic [64:0] acc_next_s;
    logic [32:0] div_shift_s;
    logic [32:0] div_trial_s;
    logic [31:0] rem_next_s;
    logic [31:0] quo_next_s;
    logic [31:0] hi_res_s;
    logic [31:0] lo_res_s;

    // Magnitude of a signed 32-bit value; |-2^31| wraps to 0x80000000, which is
    // exactly the unsigned magnitude the divider needs.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        if (v[31]) begin
            abs32 = 32'd0 - v;
        end else begin
            abs32 = v;
        end
    endfunction

    // Next-state decode for the operation sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (MultStart) begin
                    state_s = ST_MULT;
                end else if (DivStart && (B != 32'd0)) begin
                    state_s = ST_DIV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MULT: begin
                if (count_r == 6'd1) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_MULT;
                end
            end
            ST_DIV: begin
                if (count_r == 6'd1) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_DIV;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Single Booth step, single restoring-division step and final result fix-up.
    always_comb begin
        // The add/subtract is done one bit wider than the accumulator's upper
        // half so that the bit shifted in is the true sign; with a 32-bit sum,
        // 0 - (-2^31) would overflow and the product of -2^31 * -2^31 would
        // come out negative.
        booth_upper_s = {acc_r[64], acc_r[64:33]};
        case (acc_r[1:0])
            2'b01:   booth_sum_s = booth_upper_s + {mcand_r[31], mcand_r};
            2'b10:   booth_sum_s = booth_upper_s - {mcand_r[31], mcand_r};
            default: booth_sum_s = booth_upper_s;
        endcase
        acc_next_s = {booth_sum_s, acc_r[32:1]};

        // The partial remainder is always below the divisor (at most 2^31 - 1),
        // so the shifted value fits in 32 bits and a 33-bit trial gives the sign.
        div_shift_s = {rem_r, quo_r[31]};
        div_trial_s = div_shift_s - {1'b0, divisor_r};
        if (!div_trial_s[32]) begin
            rem_next_s = div_trial_s[31:0];
            quo_next_s = {quo_r[30:0], 1'b1};
        end else begin
            rem_next_s = div_shift_s[31:0];
            quo_next_s = {quo_r[30:0], 1'b0};
        end

        if (is_div_r) begin
            hi_res_s = sign_a_r ? (32'd0 - rem_r) : rem_r;
            lo_res_s = (sign_a_r ^ sign_b_r) ? (32'd0 - quo_r) : quo_r;
        end else begin
            hi_res_s = acc_r[64:33];
            lo_res_s = acc_r[32:1];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latching, iteration datapath, result registers and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r     <= 65'd0;
            mcand_r   <= 32'd0;
            divisor_r <= 32'd0;
            rem_r     <= 32'd0;
            quo_r     <= 32'd0;
            count_r   <= 6'd0;
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            is_div_r  <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            done_r    <= 1'b0;
            divzero_r <= 1'b0;
        end else begin
            done_r    <= (state_r == ST_FIN);
            divzero_r <= (state_r == ST_IDLE) && !MultStart && DivStart && (B == 32'd0);
            case (state_r)
                ST_IDLE: begin
                    if (MultStart) begin
                        mcand_r  <= A;
                        acc_r    <= {32'd0, B, 1'b0};
                        count_r  <= 6'd32;
                        is_div_r <= 1'b0;
                    end else if (DivStart && (B != 32'd0)) begin
                        quo_r     <= abs32(A);
                        divisor_r <= abs32(B);
                        rem_r     <= 32'd0;
                        sign_a_r  <= A[31];
                        sign_b_r  <= B[31];
                        count_r   <= 6'd32;
                        is_div_r  <= 1'b1;
                    end
                end
                ST_MULT: begin
                    acc_r   <= acc_next_s;
                    count_r <= count_r - 6'd1;
                end
                ST_DIV: begin
                    rem_r   <= rem_next_s;
                    quo_r   <= quo_next_s;
                    count_r <= count_r - 6'd1;
                end
                ST_FIN: begin
                    hi_r <= hi_res_s;
                    lo_r <= lo_res_s;
                end
                default: begin
                    count_r <= 6'd0;
                end
            endcase
        end
    end

    assign Hi      = hi_r;
    assign Lo      = lo_r;
    assign Busy    = (state_r != ST_IDLE);
    assign Done    = done_r;
    assign DivZero = divzero_r;

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: directed self-checking bench for mult_div. Inputs are driven
// 1 ns after a rising edge and outputs are sampled there as well.
module tb_mult_div;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        MultStart;
    logic        DivStart;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;
    logic        DivZero;

    int n_cmp;
    int n_err;

    mult_div dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .MultStart (MultStart),
        .DivStart  (DivStart),
        .Hi        (Hi),
        .Lo        (Lo),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation (start sampled at the next edge, E0), optionally
    // pulse both starts mid-operation, then check latency, Busy span and result.
    task automatic run_op(input string tag, input logic do_mult, input logic do_div,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int disturb_at);
        int n;
        int busy_n;
        A = a;
        B = b;
        MultStart = do_mult;
        DivStart  = do_div;
        tick();
        MultStart = 1'b0;
        DivStart  = 1'b0;
        A = $urandom;
        B = $urandom;
        check_val({tag, ":busy_after_e0"}, {31'd0, Busy}, 32'd1);
        check_val({tag, ":done_low_after_e0"}, {31'd0, Done}, 32'd0);
        n = 0;
        busy_n = 0;
        while (Done !== 1'b1 && n < 100) begin
            if (Busy === 1'b1) busy_n++;
            if (n == disturb_at) begin
                MultStart = 1'b1;
                DivStart  = 1'b1;
            end else begin
                MultStart = 1'b0;
                DivStart  = 1'b0;
            end
            tick();
            n++;
        end
        MultStart = 1'b0;
        DivStart  = 1'b0;
        check_val({tag, ":latency"}, n, 32'd33);
        check_val({tag, ":busy_cycles"}, busy_n, 32'd33);
        check_val({tag, ":busy_in_done"}, {31'd0, Busy}, 32'd0);
        check_val({tag, ":hi"}, Hi, exp_hi);
        check_val({tag, ":lo"}, Lo, exp_lo);
    endtask

    initial begin
        int done_seen;
        int busy_seen;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        A = 32'd0;
        B = 32'd0;
        MultStart = 1'b0;
        DivStart  = 1'b0;
        tick();
        tick();
        check_val("rst:hi", Hi, 32'd0);
        check_val("rst:lo", Lo, 32'd0);
        check_val("rst:busy", {31'd0, Busy}, 32'd0);
        check_val("rst:done", {31'd0, Done}, 32'd0);
        check_val("rst:divzero", {31'd0, DivZero}, 32'd0);
        reset = 1'b1;
        tick();

        run_op("mul_m3x5", 1'b1, 1'b0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, -1);
        tick();
        check_val("mul_m3x5:done_one_cycle", {31'd0, Done}, 32'd0);

        run_op("mul_min_sq", 1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, -1);
        // issued in the Done cycle: back-to-back
        run_op("mul_max_sq", 1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, -1);
        run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, -1);
        run_op("div_7_m2", 1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, -1);
        run_op("div_min_m1", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, -1);
        tick();

        // divide by zero: DivZero one cycle, no Busy, no Done, Hi/Lo kept
        A = 32'd5;
        B = 32'd0;
        DivStart = 1'b1;
        tick();
        DivStart = 1'b0;
        check_val("dz:divzero", {31'd0, DivZero}, 32'd1);
        check_val("dz:busy", {31'd0, Busy}, 32'd0);
        check_val("dz:done", {31'd0, Done}, 32'd0);
        tick();
        check_val("dz:divzero_one_cycle", {31'd0, DivZero}, 32'd0);
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (Done === 1'b1) done_seen++;
            if (Busy === 1'b1) busy_seen++;
            tick();
        end
        check_val("dz:no_done", done_seen, 32'd0);
        check_val("dz:no_busy", busy_seen, 32'd0);
        check_val("dz:hi_kept", Hi, 32'h00000000);
        check_val("dz:lo_kept", Lo, 32'h80000000);

        run_op("both_starts", 1'b1, 1'b1, 32'd6, 32'd3, 32'd0, 32'd18, -1);
        run_op("div_max_min", 1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, -1);
        run_op("div_100_7_disturb", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        tick();

        // asynchronous reset in the middle of a DIV
        A = 32'd1000;
        B = 32'd3;
        DivStart = 1'b1;
        tick();
        DivStart = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_val("arst:hi", Hi, 32'd0);
        check_val("arst:lo", Lo, 32'd0);
        check_val("arst:busy", {31'd0, Busy}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        done_seen = 0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1) done_seen++;
            if (Busy === 1'b1) busy_seen++;
            tick();
        end
        check_val("arst:no_done", done_seen, 32'd0);
        check_val("arst:no_busy", busy_seen, 32'd0);

        run_op("mul_2x3_after_rst", 1'b1, 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, -1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
